egress_mac: RTL and testbench
=============================

// Module: egress_mac
// PURPOSE
//  Transmit-side Layer 2 MAC. Takes whole Ethernet frames from the core switch fabric as
//  128-bit words and serializes them into the 8-bit sof/eof/valid byte stream that the
//  ingress side consumes. Pads short frames to 60 bytes and appends the 4-byte CRC-32 FCS.
//  Enforces the inter-frame gap and keeps transmit statistics.
// PARAMETERS
//  IFG_CYCLES  12  minimum idle cycles between eof_out and the next sof_out
//  MIN_FRAME   60  minimum frame length in bytes, excluding FCS; shorter frames are zero-padded
//  CNT_W       32  width of each statistics counter
// PORTS
//  lcl_clk       input   1         125 MHz clock, rising edge
//  reset         input   1         asynchronous, active-high reset
//  sof_in        input   1         first word of a frame (qualified by valid_in)
//  eof_in        input   1         last word of a frame (qualified by valid_in)
//  valid_in      input   1         word valid; a transfer happens when valid_in && ready_out
//  data_in       input   128       frame word; data_in[127:120] is transmitted first
//  bytes_in      input   4         valid bytes in an eof_in word, MSB-aligned; 0 means 16
//  ready_out     output  1         high when the holding register is empty
//  sof_out       output  1         1-cycle pulse, one cycle before the first data byte
//  eof_out       output  1         high with the last byte, which is the last FCS byte
//  valid_out     output  1         data_out holds a valid byte
//  data_out      output  8         transmitted byte
//  tx_frames     output  CNT_W     count of good frames completed
//  tx_octets     output  CNT_W     count of bytes sent with valid_out, including pad and FCS
//  underrun_cnt  output  CNT_W     count of frames aborted because of fabric underrun
// BEHAVIOUR
//  Reset (async): all outputs 0 except ready_out = 1; counters 0; FSM goes to IDLE.
//  - Reset mid-frame drops the frame immediately. No eof_out is issued.
//  Datapath: a 1-word holding register feeds a 16-byte shift register.
//  - The shifter reloads from the holding register in the same cycle as its last byte,
//    so there is no bubble.
//  - ready_out = !hold_full.
//  FSM: IDLE -> SOF -> DATA -> PAD -> FCS -> IFG -> IDLE. DROP is entered on underrun.
//  - IDLE: an accepted word with sof_in goes to SOF. Words without sof_in are accepted and discarded.
//  - SOF: sof_out = 1 and valid_out = 0 for one cycle. Latency: word accepted at t ->
//    sof_out at t+1 -> first byte at t+2.
//  - DATA: one byte per cycle with valid_out = 1.
//    - After the last byte of the eof_in word: go to PAD if byte count < MIN_FRAME, else to FCS.
//    - eof_in with bytes_in = 1..15 emits only the top bytes_in bytes.
//  - PAD: emit 0x00 until MIN_FRAME bytes have been sent, then go to FCS.
//  - FCS: 4 bytes, then go to IFG.
//    - CRC-32: poly 0xEDB88320 (reflected), init 0xFFFFFFFF, data LSB-first.
//    - Computed over data and pad bytes.
//    - FCS = ~crc, sent as crc[7:0] first. eof_out is asserted on the 4th FCS byte.
//  - IFG: valid_out = 0 for IFG_CYCLES cycles; ready_out still follows the holding register.
//    - The next frame's sof_out is issued no earlier than IFG_CYCLES+1 cycles after eof_out.
//  Underrun: the shifter finishes a non-eof word while the holding register is empty.
//  - Go straight to FCS with no pad, and send the inverted FCS (deliberately bad CRC).
//  - Assert eof_out, increment underrun_cnt, and do not increment tx_frames.
//  - Then go to DROP: accept and discard words up to and including eof_in, then go to IFG.
//    If eof_in was already accepted, go straight to IFG.
//  Counters:
//  - tx_frames increments on the eof_out of a good frame.
//  - tx_octets increments once per valid_out byte.
//  - All counters wrap modulo 2^CNT_W.
//  Simultaneous events: a word accept and a shifter reload in the same cycle is legal.
//  sof_in together with eof_in marks a single-word frame.
//  Within a frame, sof_in on a later word is ignored and the word is treated as data.
// TESTING
//  1. 1-word frame, bytes_in = 1, data 0xAA -> sof_out, 0xAA, 59x 0x00, 4 FCS bytes matching
//     the model; 64 valid_out cycles; eof_out on the 64th byte; tx_octets = 64.
//  2. 4-word frame of 64 bytes, back-to-back -> no valid_out gaps, no pad, 68 bytes;
//     tx_frames = 1.
//  3. Two frames queued -> exactly 12 idle cycles between eof_out and the 2nd sof_out.
//  4. Valid_in withheld after the 1st of 3 words -> 16 data bytes, then the inverted FCS
//     with eof_out; underrun_cnt = 1; tx_frames = 0; the remaining 2 words are discarded.
//  5. Reset asserted mid-DATA -> outputs 0 asynchronously; no eof_out; the next frame is
//     sent cleanly.
//  6. Payload "123456789" padded to 60 bytes -> FCS equals the software CRC-32 of the
//     60 bytes; ready_out low while the holding register is full.

Source files
------------

// File: rtl/egress_mac.sv
// Transmit MAC: accepts 128-bit fabric words and serialises them into a sof/eof/valid byte
// stream, zero-padding short frames, appending CRC-32 FCS and enforcing the inter-frame gap.
module egress_mac #(
    parameter int unsigned IFG_CYCLES = 12,
    parameter int unsigned MIN_FRAME  = 60,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             lcl_clk,
    input  logic             reset,
    input  logic             sof_in,
    input  logic             eof_in,
    input  logic             valid_in,
    input  logic [127:0]     data_in,
    input  logic [3:0]       bytes_in,
    output logic             ready_out,
    output logic             sof_out,
    output logic             eof_out,
    output logic             valid_out,
    output logic [7:0]       data_out,
    output logic [CNT_W-1:0] tx_frames,
    output logic [CNT_W-1:0] tx_octets,
    output logic [CNT_W-1:0] underrun_cnt
);
    localparam int unsigned LEN_W = $clog2(MIN_FRAME + 1);
    localparam int unsigned IFG_W = $clog2(IFG_CYCLES + 1);
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    typedef enum logic [2:0] {IDLE, SOF, DATA, PAD, FCS, IFG, DROP} state_e;

    state_e             state_q, state_d;
    logic               hold_full_q, hold_sof_q, hold_eof_q;
    logic [127:0]       hold_data_q;
    logic [3:0]         hold_bytes_q;
    logic [127:0]       sh_q, sh_d;
    logic [4:0]         sh_cnt_q, sh_cnt_d;
    logic               sh_eof_q, sh_eof_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        crc_q, crc_d;
    logic [1:0]         fcs_idx_q, fcs_idx_d;
    logic               bad_q, bad_d;
    logic               drop_eof_q, drop_eof_d;
    logic [IFG_W-1:0]   ifg_q, ifg_d;
    logic               sof_q, sof_d, eof_q, eof_d, valid_q, valid_d;
    logic [7:0]         data_q, data_d;
    logic [CNT_W-1:0]   frames_q, octets_q, underrun_q;
    logic               accept_c, pop_c, crc_en_c;
    logic [4:0]         hold_nb_c;
    logic [LEN_W-1:0]   len_inc_c;
    logic [31:0]        fcs_c;

    // Reflected CRC-32 update for one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h000000, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign accept_c  = valid_in && !hold_full_q;
    assign hold_nb_c = (hold_eof_q && hold_bytes_q != 4'd0) ? {1'b0, hold_bytes_q} : 5'd16;
    assign len_inc_c = (len_q == LEN_W'(MIN_FRAME)) ? len_q : len_q + LEN_W'(1);
    assign fcs_c     = bad_q ? crc_q : ~crc_q;

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        sh_cnt_d   = sh_cnt_q;
        sh_eof_d   = sh_eof_q;
        len_d      = len_q;
        crc_d      = crc_q;
        fcs_idx_d  = fcs_idx_q;
        bad_d      = bad_q;
        drop_eof_d = drop_eof_q;
        ifg_d      = ifg_q;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        valid_d    = 1'b0;
        data_d     = 8'h00;
        pop_c      = 1'b0;
        crc_en_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hold_full_q ? hold_sof_q : (valid_in && sof_in)) begin
                    sof_d      = 1'b1;
                    state_d    = SOF;
                    crc_d      = 32'hFFFFFFFF;
                    len_d      = '0;
                    fcs_idx_d  = '0;
                    bad_d      = 1'b0;
                    drop_eof_d = 1'b0;
                end else if (hold_full_q) begin
                    pop_c = 1'b1;
                end
            end
            // First byte comes straight from the holding register to meet the t+2 latency.
            SOF: begin
                pop_c    = 1'b1;
                valid_d  = 1'b1;
                crc_en_c = 1'b1;
                data_d   = hold_data_q[127:120];
                sh_d     = hold_data_q << 8;
                sh_cnt_d = hold_nb_c - 5'd1;
                sh_eof_d = hold_eof_q;
                if (hold_nb_c == 5'd1) begin
                    state_d = (len_inc_c < LEN_W'(MIN_FRAME)) ? PAD : FCS;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                valid_d  = 1'b1;
                crc_en_c = 1'b1;
                data_d   = sh_q[127:120];
                sh_d     = sh_q << 8;
                sh_cnt_d = sh_cnt_q - 5'd1;
                if (sh_cnt_q == 5'd1) begin
                    if (sh_eof_q) begin
                        state_d = (len_inc_c < LEN_W'(MIN_FRAME)) ? PAD : FCS;
                    end else if (hold_full_q) begin
                        pop_c    = 1'b1;
                        sh_d     = hold_data_q;
                        sh_cnt_d = hold_nb_c;
                        sh_eof_d = hold_eof_q;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = FCS;
                    end
                end
            end
            PAD: begin
                valid_d  = 1'b1;
                crc_en_c = 1'b1;
                if (len_inc_c == LEN_W'(MIN_FRAME)) state_d = FCS;
            end
            // An aborted frame keeps discarding its remaining words while the bad FCS goes out.
            FCS: begin
                valid_d   = 1'b1;
                data_d    = fcs_c[{fcs_idx_q, 3'b000} +: 8];
                fcs_idx_d = fcs_idx_q + 2'd1;
                if (bad_q && !drop_eof_q && hold_full_q) begin
                    pop_c = 1'b1;
                    if (hold_eof_q) drop_eof_d = 1'b1;
                end
                if (fcs_idx_q == 2'd3) begin
                    eof_d   = 1'b1;
                    ifg_d   = '0;
                    state_d = (bad_q && !drop_eof_d) ? DROP : IFG;
                end
            end
            IFG: begin
                if (ifg_q == IFG_W'(IFG_CYCLES - 1)) state_d = IDLE;
                else ifg_d = ifg_q + IFG_W'(1);
            end
            DROP: begin
                if (hold_full_q) begin
                    pop_c = 1'b1;
                    if (hold_eof_q) begin
                        ifg_d   = '0;
                        state_d = IFG;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (crc_en_c) begin
            crc_d = crc_byte(crc_q, data_d);
            len_d = len_inc_c;
        end
    end

    always_ff @(posedge lcl_clk or posedge reset) begin
        if (reset) begin
            hold_full_q  <= 1'b0;
            hold_sof_q   <= 1'b0;
            hold_eof_q   <= 1'b0;
            hold_data_q  <= '0;
            hold_bytes_q <= '0;
        end else if (accept_c) begin
            hold_full_q  <= 1'b1;
            hold_sof_q   <= sof_in;
            hold_eof_q   <= eof_in;
            hold_data_q  <= data_in;
            hold_bytes_q <= bytes_in;
        end else if (pop_c) begin
            hold_full_q  <= 1'b0;
        end
    end

    always_ff @(posedge lcl_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            sh_cnt_q   <= '0;
            sh_eof_q   <= 1'b0;
            len_q      <= '0;
            crc_q      <= '0;
            fcs_idx_q  <= '0;
            bad_q      <= 1'b0;
            drop_eof_q <= 1'b0;
            ifg_q      <= '0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            frames_q   <= '0;
            octets_q   <= '0;
            underrun_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            sh_cnt_q   <= sh_cnt_d;
            sh_eof_q   <= sh_eof_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            fcs_idx_q  <= fcs_idx_d;
            bad_q      <= bad_d;
            drop_eof_q <= drop_eof_d;
            ifg_q      <= ifg_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            if (valid_d) octets_q <= octets_q + CNT_W'(1);
            if (eof_d && !bad_q) frames_q <= frames_q + CNT_W'(1);
            if (eof_d && bad_q) underrun_q <= underrun_q + CNT_W'(1);
        end
    end

    assign ready_out    = !hold_full_q;
    assign sof_out      = sof_q;
    assign eof_out      = eof_q;
    assign valid_out    = valid_q;
    assign data_out     = data_q;
    assign tx_frames    = frames_q;
    assign tx_octets    = octets_q;
    assign underrun_cnt = underrun_q;

endmodule

// File: tb/tb_egress_mac.sv
// Scoreboard bench for egress_mac: a frame-level model queues the expected byte stream,
// an independent monitor pops and compares whatever the DUT emits.
module tb_egress_mac;
    localparam int IFG  = 12;
    localparam int MINF = 60;

    typedef struct packed { bit mk; bit [7:0] d; bit e; } exp_t;

    logic         lcl_clk, reset, sof_in, eof_in, valid_in;
    logic [127:0] data_in;
    logic [3:0]   bytes_in;
    logic         ready_out, sof_out, eof_out, valid_out;
    logic [7:0]   data_out;
    logic [31:0]  tx_frames, tx_octets, underrun_cnt;

    egress_mac #(.IFG_CYCLES(IFG), .MIN_FRAME(MINF), .CNT_W(32)) dut (
        .lcl_clk(lcl_clk), .reset(reset), .sof_in(sof_in), .eof_in(eof_in),
        .valid_in(valid_in), .data_in(data_in), .bytes_in(bytes_in),
        .ready_out(ready_out), .sof_out(sof_out), .eof_out(eof_out),
        .valid_out(valid_out), .data_out(data_out), .tx_frames(tx_frames),
        .tx_octets(tx_octets), .underrun_cnt(underrun_cnt)
    );

    exp_t   exp_q[$];
    int     n_vec = 0, n_err = 0;
    int     cyc = 0;
    int     sof_cyc = 0, first_cyc = 0, eof_cyc = 0, fr_valid = 0, fr_len = 0, last_gap = 0;
    bit     have_eof = 0;
    int     last_acc = 0, first_acc = 0;
    longint m_frames = 0, m_octets = 0, m_underruns = 0;

    initial lcl_clk = 1'b0;
    always #4 lcl_clk = ~lcl_clk;
    always @(posedge lcl_clk) cyc <= cyc + 1;

    initial begin
        #(8 * 60000);
        $display("FAIL watchdog: still running after %0d cycles, required completion", 60000);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit [31:0] crc32(input bit [7:0] p[$]);
        bit [31:0] c = 32'hFFFFFFFF;
        foreach (p[i]) begin
            c ^= {24'h0, p[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Good frame: payload, zero pad to the minimum, FCS low byte first, eof on the last.
    function automatic void model_good(input bit [7:0] fb[$]);
        bit [7:0]  p[$];
        bit [31:0] c;
        p = fb;
        while (p.size() < MINF) p.push_back(8'h00);
        c = crc32(p);
        exp_q.push_back('{mk: 1'b1, d: 8'h00, e: 1'b0});
        foreach (p[i]) exp_q.push_back('{mk: 1'b0, d: p[i], e: 1'b0});
        for (int k = 0; k < 4; k++) exp_q.push_back('{mk: 1'b0, d: c[8*k +: 8], e: (k == 3)});
        m_frames++;
        m_octets += p.size() + 4;
    endfunction

    // Aborted frame: only what was sent so far, no pad, complemented FCS.
    function automatic void model_underrun(input bit [7:0] p[$]);
        bit [31:0] c;
        c = ~crc32(p);
        exp_q.push_back('{mk: 1'b1, d: 8'h00, e: 1'b0});
        foreach (p[i]) exp_q.push_back('{mk: 1'b0, d: p[i], e: 1'b0});
        for (int k = 0; k < 4; k++) exp_q.push_back('{mk: 1'b0, d: c[8*k +: 8], e: (k == 3)});
        m_underruns++;
        m_octets += p.size() + 4;
    endfunction

    task automatic send_word(input bit s, input bit e, input logic [127:0] d, input logic [3:0] nb);
        int w = 0;
        @(negedge lcl_clk);
        sof_in = s; eof_in = e; data_in = d; bytes_in = nb; valid_in = 1'b1;
        while (!ready_out && w < 2000) begin
            @(negedge lcl_clk);
            w++;
        end
        check("accept_ready", ready_out, 1);
        last_acc = cyc + 1;
        @(posedge lcl_clk);
        #1 valid_in = 1'b0;
    endtask

    function automatic logic [127:0] pack_word(input bit [7:0] fb[$], input int w, input int nb);
        logic [127:0] d = '0;
        for (int b = 0; b < nb; b++) d[127 - 8*b -: 8] = fb[16*w + b];
        return d;
    endfunction

    task automatic send_frame(input bit [7:0] fb[$], input int max_gap);
        int n, nw, nb;
        n  = fb.size();
        nw = (n + 15) / 16;
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? n - 16*w : 16;
            send_word(w == 0, w == nw - 1, pack_word(fb, w, nb), 4'(nb));
            if (w == 0) first_acc = last_acc;
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge lcl_clk);
        end
    endtask

    function automatic void rand_bytes(output bit [7:0] fb[$], input int n);
        fb.delete();
        for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(255, 0)));
    endfunction

    task automatic wait_drain(input string name);
        int w = 0;
        while (exp_q.size() != 0 && w < 5000) begin
            @(negedge lcl_clk);
            w++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (IFG + 4) @(negedge lcl_clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge lcl_clk);
            if (reset) begin
                have_eof = 0;
            end else begin
                if (sof_out) begin
                    check("sof_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sof_order", e.mk, 1);
                    end
                    if (have_eof) check("ifg_min_gap", (cyc - eof_cyc) >= IFG + 1, 1);
                    last_gap = cyc - eof_cyc;
                    sof_cyc  = cyc;
                    fr_valid = 0;
                end
                if (valid_out) begin
                    check("byte_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("byte_order", e.mk, 0);
                        check("data_out", data_out, e.d);
                        check("eof_out", eof_out, e.e);
                    end
                    fr_valid++;
                    if (fr_valid == 1) first_cyc = cyc;
                    if (eof_out) begin
                        have_eof = 1;
                        eof_cyc  = cyc;
                        fr_len   = fr_valid;
                    end
                end else if (eof_out) begin
                    check("eof_without_valid", valid_out, 1);
                end
            end
        end
    end

    initial begin : stim
        bit [7:0] fb[$], fb2[$], head[$];
        reset = 1'b1; sof_in = 1'b0; eof_in = 1'b0; valid_in = 1'b0;
        data_in = '0; bytes_in = '0;
        repeat (3) @(negedge lcl_clk);
        check("rst_ready", ready_out, 1);
        check("rst_sof", sof_out, 0);
        check("rst_eof", eof_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_data", data_out, 0);
        check("rst_counters", {tx_frames, tx_octets} | 64'(underrun_cnt), 0);
        reset = 1'b0;

        // single 1-byte word, padded to 60
        fb.delete(); fb.push_back(8'hAA);
        model_good(fb);
        send_frame(fb, 0);
        wait_drain("t1");
        check("t1_sof_latency", sof_cyc - first_acc, 0);
        check("t1_first_byte_latency", first_cyc - first_acc, 1);
        check("t1_valid_cycles", fr_len, 64);
        check("t1_tx_octets", tx_octets, 64);
        check("t1_tx_frames", tx_frames, 1);

        // 64 bytes back-to-back, no pad
        rand_bytes(fb, 64);
        model_good(fb);
        send_frame(fb, 0);
        wait_drain("t2");
        check("t2_valid_cycles", fr_len, 68);
        check("t2_no_gaps", eof_cyc - first_cyc + 1, 68);
        check("t2_tx_frames", tx_frames, 2);

        // two queued frames: exact inter-frame gap
        rand_bytes(fb, 20);
        rand_bytes(fb2, 30);
        model_good(fb);
        model_good(fb2);
        send_frame(fb, 0);
        send_frame(fb2, 0);
        wait_drain("t3");
        check("t3_sof_after_eof", last_gap, IFG + 1);
        check("t3_tx_frames", tx_frames, m_frames);

        // underrun after the first of three words; remaining words dropped
        rand_bytes(fb, 48);
        head = fb[0:15];
        model_underrun(head);
        send_word(1'b1, 1'b0, pack_word(fb, 0, 16), 4'd0);
        wait_drain("t4");
        send_word(1'b0, 1'b0, pack_word(fb, 1, 16), 4'd0);
        send_word(1'b0, 1'b1, pack_word(fb, 2, 16), 4'd0);
        repeat (40) @(negedge lcl_clk);
        check("t4_underrun_cnt", underrun_cnt, 1);
        check("t4_tx_frames", tx_frames, m_frames);
        check("t4_tx_octets", tx_octets, m_octets);
        check("t4_ready_after_drop", ready_out, 1);

        // asynchronous reset in the middle of DATA
        rand_bytes(fb, 16);
        model_good(fb);
        send_frame(fb, 0);
        repeat (6) @(negedge lcl_clk);
        check("t5_valid_before_reset", valid_out, 1);
        #1 reset = 1'b1;
        #1;
        check("t5_async_valid", valid_out, 0);
        check("t5_async_data", data_out, 0);
        check("t5_async_sof_eof", {sof_out, eof_out}, 0);
        check("t5_async_ready", ready_out, 1);
        check("t5_async_counters", {tx_frames, tx_octets} | 64'(underrun_cnt), 0);
        exp_q.delete();
        m_frames = 0; m_octets = 0; m_underruns = 0;
        repeat (3) @(negedge lcl_clk);
        reset = 1'b0;
        repeat (20) @(negedge lcl_clk);
        rand_bytes(fb, 40);
        model_good(fb);
        send_frame(fb, 0);
        wait_drain("t5");
        check("t5_tx_frames", tx_frames, 1);
        check("t5_tx_octets", tx_octets, 64);

        // "123456789" padded; holding register occupancy on ready_out
        fb.delete();
        for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
        model_good(fb);
        send_frame(fb, 0);
        @(negedge lcl_clk);
        check("t6_ready_while_full", ready_out, 0);
        @(negedge lcl_clk);
        check("t6_ready_after_load", ready_out, 1);
        wait_drain("t6");
        check("t6_valid_cycles", fr_len, 64);

        // randomized frames with random gaps
        for (int f = 0; f < 25; f++) begin
            rand_bytes(fb, $urandom_range(100, 1));
            model_good(fb);
            send_frame(fb, 3);
            repeat ($urandom_range(20, 0)) @(negedge lcl_clk);
        end
        wait_drain("rand");
        check("final_tx_frames", tx_frames, m_frames);
        check("final_tx_octets", tx_octets, m_octets);
        check("final_underrun_cnt", underrun_cnt, m_underruns);

        repeat (5) @(negedge lcl_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
